// File: rtl/rast_pipe_elastic.sv
// Parametrised valid/ready delay line for the rasterizer datapath.
// MODE 0 advances all stages together; MODE 1 lets empty stages collapse toward the tail.
module rast_pipe_elastic #(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned MODE       = 1,
  parameter bit          RESET_DATA = 1'b0
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            flush_i,
  input  logic                                            in_valid_i,
  output logic                                            in_ready_o,
  input  logic [WIDTH-1:0]                                in_data_i,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic [WIDTH-1:0]                                out_data_o,
  output logic [((DEPTH < 2) ? 1 : $clog2(DEPTH + 1))-1:0] occupancy_o
);

  localparam int unsigned OccW = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);

  if (MODE > 1 || DEPTH > 16) begin : g_bad_param
    $error("rast_pipe_elastic: illegal parameters (MODE must be 0..1, DEPTH 0..16)");
  end

  if (DEPTH == 0) begin : g_wire
    logic unused_wire;
    assign unused_wire = ^{clk_i, rst_ni, flush_i};

    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign out_data_o  = in_data_i;
    assign occupancy_o = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] v_q, v_d, en, ld;
    logic [OccW-1:0]  occ_q, occ_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic             tail_run;

    // Stage enables, resolved from the tail toward the head.
    always_comb begin
      en       = '0;
      tail_run = ~v_q[DEPTH-1] | out_ready_i;
      if (MODE == 0) begin
        en = {DEPTH{tail_run}};
      end else begin
        en[DEPTH-1] = tail_run;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
          tail_run = ~v_q[i] | tail_run;
          en[i]    = tail_run;
        end
      end
    end

    always_comb begin
      v_d = v_q;
      ld  = '0;
      if (en[0]) begin
        v_d[0] = in_valid_i;
        ld[0]  = in_valid_i;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (en[i]) begin
          v_d[i] = v_q[i-1];
          ld[i]  = v_q[i-1];
        end
      end
      if (flush_i) begin
        v_d = '0;
      end
      occ_d = OccW'($countones(v_d));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q   <= '0;
        occ_q <= '0;
      end else begin
        v_q   <= v_d;
        occ_q <= occ_d;
      end
    end

    // Payload only moves with a valid beat; bubbles leave stale data behind.
    if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            d_q[i] <= '0;
          end
        end else begin
          if (ld[0]) d_q[0] <= in_data_i;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            if (ld[i]) d_q[i] <= d_q[i-1];
          end
        end
      end
    end else begin : g_data
      always_ff @(posedge clk_i) begin
        if (ld[0]) d_q[0] <= in_data_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          if (ld[i]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign in_ready_o  = en[0] & ~flush_i;
    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];
    assign occupancy_o = occ_q;
  end

endmodule

// File: tb/tb_rast_pipe_elastic.sv
// Self-checking bench for rast_pipe_elastic: directed tables, corner sequences and a
// randomised scoreboard run across several DEPTH/MODE configurations in parallel.
module tb_rast_pipe_elastic;

  localparam int W      = 24;
  localparam int NK     = 6;
  localparam int NBEATS = 10000;

  function automatic int unsigned dep_of(input int k);
    case (k)
      0, 1:    return 3;
      2:       return 0;
      3:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned mode_of(input int k);
    case (k)
      0, 2, 5: return 1;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    int           occ;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [NK];
  logic         ordy [NK];
  logic         fl   [NK];
  logic [W-1:0] id   [NK];
  logic         ir   [NK];
  logic         ov   [NK];
  logic [W-1:0] od   [NK];
  logic [7:0]   occ  [NK];

  logic [W-1:0] q [NK][$];
  logic         prev_stall [NK];
  logic [W-1:0] prev_od    [NK];
  logic         acc_last   [NK];
  int           n_in  [NK];
  int           n_out [NK];
  int           n_pass  = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NK; g++) begin : g_dut
    localparam int unsigned D  = dep_of(g);
    localparam int unsigned OW = (D < 2) ? 1 : $clog2(D + 1);
    logic [OW-1:0] occ_l;

    rast_pipe_elastic #(
      .WIDTH     (W),
      .DEPTH     (D),
      .MODE      (mode_of(g)),
      .RESET_DATA(g == 0)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (fl[g]),
      .in_valid_i (iv[g]),
      .in_ready_o (ir[g]),
      .in_data_i  (id[g]),
      .out_valid_o(ov[g]),
      .out_ready_i(ordy[g]),
      .out_data_o (od[g]),
      .occupancy_o(occ_l)
    );

    assign occ[g] = 8'(occ_l);
  end

  task automatic chk(input string name, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
  endtask

  // Scoreboard and protocol monitor for every instance, run once per negedge.
  task automatic monitor();
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        q[k].delete();
        prev_stall[k] = 1'b0;
        acc_last[k]   = 1'b0;
        continue;
      end
      chk("occupancy", k, occ[k], q[k].size());
      if (dep_of(k) == 0) begin
        chk("pass_ready", k, ir[k], ordy[k]);
        chk("pass_valid", k, ov[k], iv[k]);
      end else if (fl[k]) begin
        chk("flush_ready", k, ir[k], 0);
      end
      if (prev_stall[k]) begin
        chk("stall_valid", k, ov[k], 1);
        chk("stall_data", k, od[k], prev_od[k]);
      end
      acc_last[k] = iv[k] & ir[k];
      if (acc_last[k]) begin
        q[k].push_back(id[k]);
        n_in[k]++;
      end
      if (ov[k] & ordy[k]) begin
        chk("out_has_beat", k, 64'(q[k].size() != 0), 1);
        if (q[k].size() != 0) chk("out_data", k, od[k], q[k].pop_front());
        n_out[k]++;
      end
      if (fl[k] && dep_of(k) != 0) q[k].delete();
      prev_stall[k] = ov[k] & ~ordy[k] & ~(fl[k] && dep_of(k) != 0);
      prev_od[k]    = od[k];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r,
                              input logic e_ir, input logic e_ov, input logic [W-1:0] e_od,
                              input int e_occ);
    vec_t t;
    t.iv = v; t.d = d; t.ordy = r; t.ir = e_ir; t.ov = e_ov; t.od = e_od; t.occ = e_occ;
    return t;
  endfunction

  task automatic apply_vec(input int k, input vec_t v, input int idx);
    iv[k]   = v.iv;
    id[k]   = v.d;
    ordy[k] = v.ordy;
    sample();
    chk("tab_in_ready", idx, ir[k], v.ir);
    chk("tab_out_valid", idx, ov[k], v.ov);
    chk("tab_occupancy", idx, occ[k], v.occ);
    if (v.ov) chk("tab_out_data", idx, od[k], v.od);
    advance();
  endtask

  task automatic stream(input int k, input int n, input logic [W-1:0] base,
                        output int first, output int nhi, output int peak);
    first   = -1;
    nhi     = 0;
    peak    = 0;
    ordy[k] = 1'b1;
    iv[k]   = 1'b1;
    id[k]   = base;
    for (int c = 0; c < n + 8; c++) begin
      sample();
      if (ov[k]) begin
        if (first < 0) first = c;
        nhi++;
      end
      if (int'(occ[k]) > peak) peak = int'(occ[k]);
      advance();
      if (c + 1 < n) id[k] = base + W'(c + 1);
      else iv[k] = 1'b0;
    end
  endtask

  task automatic fill3(input logic [W-1:0] base);
    ordy[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iv[0] = 1'b1;
      id[0] = base + W'(j);
      sample();
      advance();
    end
    iv[0] = 1'b0;
  endtask

  initial begin
    vec_t tab_e [11];
    vec_t tab_l [11];
    int   first, nhi, peak, cyc;
    bit   busy;

    tab_e[0]  = mk(1, 'hA, 0, 1, 0, 0,   0);
    tab_e[1]  = mk(0, 0,   0, 1, 0, 0,   1);
    tab_e[2]  = mk(1, 'hB, 0, 1, 0, 0,   1);
    tab_e[3]  = mk(0, 0,   0, 1, 1, 'hA, 2);
    tab_e[4]  = mk(1, 'hC, 0, 1, 1, 'hA, 2);
    tab_e[5]  = mk(1, 'hD, 0, 0, 1, 'hA, 3);
    tab_e[6]  = mk(1, 'hD, 1, 1, 1, 'hA, 3);
    tab_e[7]  = mk(0, 0,   1, 1, 1, 'hB, 3);
    tab_e[8]  = mk(0, 0,   1, 1, 1, 'hC, 2);
    tab_e[9]  = mk(0, 0,   1, 1, 1, 'hD, 1);
    tab_e[10] = mk(0, 0,   1, 1, 0, 0,   0);

    tab_l[0]  = mk(1, 'hA, 0, 1, 0, 0,   0);
    tab_l[1]  = mk(0, 0,   0, 1, 0, 0,   1);
    tab_l[2]  = mk(1, 'hB, 0, 1, 0, 0,   1);
    tab_l[3]  = mk(0, 0,   0, 0, 1, 'hA, 2);
    tab_l[4]  = mk(1, 'hC, 0, 0, 1, 'hA, 2);
    tab_l[5]  = mk(1, 'hC, 0, 0, 1, 'hA, 2);
    tab_l[6]  = mk(1, 'hC, 1, 1, 1, 'hA, 2);
    tab_l[7]  = mk(0, 0,   1, 1, 0, 0,   2);
    tab_l[8]  = mk(0, 0,   1, 1, 1, 'hB, 2);
    tab_l[9]  = mk(0, 0,   1, 1, 1, 'hC, 1);
    tab_l[10] = mk(0, 0,   1, 1, 0, 0,   0);

    for (int k = 0; k < NK; k++) begin
      iv[k] = 0; ordy[k] = 0; fl[k] = 0; id[k] = '0;
      prev_stall[k] = 0; prev_od[k] = '0; acc_last[k] = 0; n_in[k] = 0; n_out[k] = 0;
    end
    rst_n = 1'b0;
    #12;
    chk("reset_out_valid", 0, ov[0], 0);
    chk("reset_occupancy", 0, occ[0], 0);
    chk("reset_out_data", 0, od[0], 0);
    chk("reset_in_ready_elastic", 0, ir[0], 1);
    chk("reset_in_ready_lockstep", 1, ir[1], 1);
    advance();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(0, tab_e[i], i);
    iv[0] = 0; ordy[0] = 0;
    for (int i = 0; i < 11; i++) apply_vec(1, tab_l[i], 100 + i);
    iv[1] = 0; ordy[1] = 0;

    stream(0, 5, 24'h000001, first, nhi, peak);
    chk("stream_latency", 0, first, 3);
    chk("stream_no_gaps", 0, nhi, 5);
    chk("stream_peak_occ", 0, peak, 3);
    stream(1, 5, 24'h000101, first, nhi, peak);
    chk("stream_latency", 1, first, 3);
    chk("stream_no_gaps", 1, nhi, 5);

    fill3(24'h000011);
    fl[0] = 1; iv[0] = 1; id[0] = 24'h000014;
    sample();
    chk("flush_stall_in_ready", 0, ir[0], 0);
    chk("flush_stall_out_valid", 0, ov[0], 1);
    advance();
    fl[0] = 0; iv[0] = 0;
    sample();
    chk("post_flush_occ", 0, occ[0], 0);
    chk("post_flush_valid", 0, ov[0], 0);
    advance();

    fill3(24'h000021);
    fl[0] = 1; ordy[0] = 1;
    sample();
    chk("flush_drain_in_ready", 0, ir[0], 0);
    chk("flush_drain_out_data", 0, od[0], 24'h000021);
    advance();
    fl[0] = 0; ordy[0] = 0;
    sample();
    chk("post_flush2_occ", 0, occ[0], 0);
    chk("post_flush2_valid", 0, ov[0], 0);
    advance();
    stream(0, 1, 24'h000030, first, nhi, peak);
    chk("post_flush_latency", 0, first, 3);
    chk("post_flush_beats", 0, nhi, 1);

    ordy[0] = 0; iv[0] = 1; id[0] = 24'h000041;
    sample(); advance();
    id[0] = 24'h000042;
    sample(); advance();
    iv[0] = 0;
    sample(); advance();
    sample();
    chk("pre_reset_occ", 0, occ[0], 2);
    chk("pre_reset_valid", 0, ov[0], 1);
    advance();
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 0, ov[0], 0);
    chk("async_reset_occ", 0, occ[0], 0);
    chk("async_reset_data", 0, od[0], 0);
    sample(); advance();
    sample(); advance();
    rst_n = 1'b1;
    stream(0, 1, 24'h000050, first, nhi, peak);
    chk("post_reset_latency", 0, first, 3);
    chk("post_reset_beats", 0, nhi, 1);

    for (int k = 0; k < NK; k++) begin
      iv[k] = 0; ordy[k] = 0; fl[k] = 0; acc_last[k] = 0; n_in[k] = 0; n_out[k] = 0;
    end
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 70000) begin
      for (int k = 0; k < NK; k++) begin
        if (!(iv[k] && !acc_last[k])) begin
          if (n_in[k] < NBEATS) begin
            iv[k] = 1'($urandom_range(0, 1));
            id[k] = W'($urandom);
          end else begin
            iv[k] = 1'b0;
          end
        end
        ordy[k] = 1'($urandom_range(0, 1));
      end
      sample();
      advance();
      cyc++;
      busy = 1'b0;
      for (int k = 0; k < NK; k++) if (n_in[k] < NBEATS) busy = 1'b1;
    end
    for (int k = 0; k < NK; k++) begin
      iv[k] = 0; ordy[k] = 1;
    end
    repeat (20) begin
      sample();
      advance();
    end
    for (int k = 0; k < NK; k++) begin
      chk("rand_accepted", k, 64'(n_in[k] >= NBEATS), 1);
      chk("rand_drained", k, q[k].size(), 0);
      chk("rand_count", k, n_out[k], n_in[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
